modinv_scheduler: RTL and testbench

MODINV_SCHEDULER -- requirements
Module: modinv_scheduler

---
 rtl/ecc_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/modinv_scheduler.sv | 125 ++++++++++++
 tb/tb_modinv_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the modular-inverse scheduling slice: scheduler states,
// default operand width and the engine timeout derived from it.
package ecc_pkg;

  localparam int N_DEFAULT = 231;

  function automatic int tmax_for(input int n);
    return 4 * n + 16;
  endfunction

  localparam int TMAX_DEFAULT = tmax_for(N_DEFAULT);

  // Width of an index into n requesters; never zero so the ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts one past the
// last granted index; the pointer moves only when the grant is taken.
module rr_arbiter
  import ecc_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] request,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PW = id_width(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop, otherwise the
    // paths where no request is found would infer latches.
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/modinv_scheduler.sv
// Shares one modular-inverse engine between NREQ requesters: round-robin grant,
// zero-operand short cut, engine timeout and a held response handshake.
module modinv_scheduler
  import ecc_pkg::*;
#(
  parameter  int N    = N_DEFAULT,
  parameter  int NREQ = 4,
  parameter  int TMAX = tmax_for(N),
  localparam int IW   = id_width(NREQ),
  localparam int CW   = $clog2(TMAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    p,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*N-1:0] req_a,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic [N-1:0]    rsp_x,
  output logic            rsp_err,
  output logic [CW-1:0]   rsp_cycles,
  input  logic            rsp_ready,
  output logic            inv_reset,
  output logic [N-1:0]    inv_a,
  output logic [N-1:0]    inv_p,
  input  logic [N-1:0]    inv_x,
  input  logic            inv_done,
  output logic            busy
);

  sched_state_t state, state_next;

  logic [NREQ-1:0] grant;
  logic            advance;
  logic [IW-1:0]   grant_id;
  logic [N-1:0]    grant_a;
  logic [N-1:0]    op_a, op_p;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            done_seen, timeout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  assign advance   = (state == IDLE) && (|req_valid) && !reset;
  assign req_ready = advance ? grant : '0;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IW'(i);
    end
    grant_a = req_a[int'(grant_id)*N +: N];
  end

  // The engine's sticky flag may still reflect its reset on the first RUN cycle.
  assign cnt_inc   = cnt + CW'(1);
  assign done_seen = (cnt != '0) && inv_done;
  assign timeout   = (cnt_inc == CW'(TMAX));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (advance) state_next = (grant_a == '0) ? RESP : RUN;
      RUN:     if (done_seen || timeout) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_a       <= '0;
      op_p       <= '0;
      cnt        <= '0;
      rsp_id     <= '0;
      rsp_x      <= '0;
      rsp_err    <= 1'b0;
      rsp_cycles <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (advance) begin
            op_a   <= grant_a;
            op_p   <= p;
            rsp_id <= grant_id;
            cnt    <= '0;
            if (grant_a == '0) begin
              rsp_x      <= '0;
              rsp_err    <= 1'b1;
              rsp_cycles <= '0;
            end
          end
        end
        RUN: begin
          cnt <= cnt_inc;
          if (done_seen) begin
            rsp_x      <= inv_x;
            rsp_err    <= 1'b0;
            rsp_cycles <= cnt_inc;
          end else if (timeout) begin
            rsp_x      <= '0;
            rsp_err    <= 1'b1;
            rsp_cycles <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign inv_reset = reset || (state != RUN);
  assign inv_a     = op_a;
  assign inv_p     = op_p;

endmodule

// File: tb/tb_modinv_scheduler.sv
// Directed bench for modinv_scheduler with N=8, p=23, TMAX=20 and a behavioural
// inverse engine that raises done a fixed delay after release (or never, when hung).
module tb_modinv_scheduler;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int TMAX = 20;

  logic            clk;
  logic            reset;
  logic [N-1:0]    p;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [N-1:0]    rsp_x;
  logic            rsp_err;
  logic [4:0]      rsp_cycles;
  logic            rsp_ready;
  logic            inv_reset;
  logic [N-1:0]    inv_a, inv_p, inv_x;
  logic            inv_done;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic hang;
  int   stub_cnt;

  modinv_scheduler #(.N(N), .NREQ(NREQ), .TMAX(TMAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .p          (p),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_x      (rsp_x),
    .rsp_err    (rsp_err),
    .rsp_cycles (rsp_cycles),
    .rsp_ready  (rsp_ready),
    .inv_reset  (inv_reset),
    .inv_a      (inv_a),
    .inv_p      (inv_p),
    .inv_x      (inv_x),
    .inv_done   (inv_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] brute_inv(input logic [N-1:0] a, input logic [N-1:0] m);
    for (int x = 1; x < int'(m); x++) begin
      if ((int'(a) * x) % int'(m) == 1) return N'(x);
    end
    return '0;
  endfunction

  // Engine stand-in: done rises on the 5th edge after release and stays set.
  always @(posedge clk) begin
    if (inv_reset) begin
      stub_cnt <= 0;
      inv_done <= 1'b0;
      inv_x    <= '0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!hang && stub_cnt == 4) begin
        inv_done <= 1'b1;
        inv_x    <= brute_inv(inv_a, inv_p);
      end
    end
  end

  task automatic issue(input int id, input logic [N-1:0] a);
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_a[id*N +: N] = a;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready != '0) begin
        g  = req_ready;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 || inv_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b inv_reset=%b want 0 0 0000 1",
               busy, rsp_valid, req_ready, inv_reset);
    end
    n_cmp++;
    if (rsp_x !== 8'd0 || rsp_err !== 1'b0 || rsp_cycles !== 5'd0 || rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_rsp: x=%0d err=%b cycles=%0d id=%0d want all zero",
               rsp_x, rsp_err, rsp_cycles, rsp_id);
    end
    req_valid = '0;
    reset     = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [NREQ-1:0] g;
    bit ok;
    issue(1, 8'd5);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_grant: got %b want 0010", g);
    end
    @(negedge clk);
    req_valid = '0;
    n_cmp++;
    if (inv_reset !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_run: inv_reset=%b busy=%b want 0 1", inv_reset, busy);
    end
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_id !== 2'd1 || rsp_x !== 8'd14 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_rsp: valid=%b id=%0d x=%0d err=%b want 1 1 14 0", ok, rsp_id, rsp_x, rsp_err);
    end
    n_cmp++;
    if (rsp_cycles !== 5'd6) begin
      n_bad++;
      $display("FAIL single_cycles: got %0d want 6", rsp_cycles);
    end
    consume();
  endtask

  task automatic test_zero;
    logic [NREQ-1:0] g;
    bit ok;
    issue(2, 8'd0);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0100) begin
      n_bad++;
      $display("FAIL zero_grant: got %b want 0100", g);
    end
    @(negedge clk);
    req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || inv_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_timing: rsp_valid=%b inv_reset=%b want 1 1", rsp_valid, inv_reset);
    end
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_x !== 8'd0 || rsp_cycles !== 5'd0 || rsp_id !== 2'd2) begin
      n_bad++;
      $display("FAIL zero_rsp: err=%b x=%0d cycles=%0d id=%0d want 1 0 0 2", rsp_err, rsp_x, rsp_cycles, rsp_id);
    end
    consume();
  endtask

  task automatic test_round_robin;
    int exp_id[4] = '{0, 2, 0, 2};
    logic [N-1:0] exp_x[4] = '{8'd8, 8'd10, 8'd8, 8'd10};
    logic [NREQ-1:0] g, exp_g;
    bit ok;
    @(negedge clk);
    req_valid = 4'b0101;
    req_a     = {8'd0, 8'd7, 8'd0, 8'd3};
    for (int k = 0; k < 4; k++) begin
      exp_g = NREQ'(1 << exp_id[k]);
      wait_grant(g, ok);
      n_cmp++;
      if (!ok || g !== exp_g) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, g, exp_g);
      end
      @(negedge clk);
      wait_rsp(ok);
      n_cmp++;
      if (!ok || rsp_id !== 2'(exp_id[k]) || rsp_x !== exp_x[k] || rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_rsp[%0d]: id=%0d x=%0d err=%b want %0d %0d 0", k, rsp_id, rsp_x, rsp_err, exp_id[k], exp_x[k]);
      end
      consume();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout;
    logic [NREQ-1:0] g;
    bit ok;
    int run;
    hang = 1'b1;
    issue(3, 8'd5);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b1000) begin
      n_bad++;
      $display("FAIL tmo_grant: got %b want 1000", g);
    end
    @(negedge clk);
    req_valid = '0;
    run = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (inv_reset === 1'b0) run++;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok || run != TMAX) begin
      n_bad++;
      $display("FAIL tmo_run_cycles: got %0d (valid=%b) want %0d", run, ok, TMAX);
    end
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_x !== 8'd0 || rsp_cycles !== 5'd20 || rsp_id !== 2'd3) begin
      n_bad++;
      $display("FAIL tmo_rsp: err=%b x=%0d cycles=%0d id=%0d want 1 0 20 3", rsp_err, rsp_x, rsp_cycles, rsp_id);
    end
    consume();
    hang = 1'b0;
    issue(1, 8'd5);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0010) begin
      n_bad++;
      $display("FAIL tmo_next_grant: got %b want 0010", g);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_x !== 8'd14 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_next_rsp: x=%0d err=%b want 14 0", rsp_x, rsp_err);
    end
    consume();
  endtask

  task automatic test_backpressure;
    logic [NREQ-1:0] g;
    bit ok;
    issue(0, 8'd3);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0001) begin
      n_bad++;
      $display("FAIL bp_grant: got %b want 0001", g);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[2*N +: N] = 8'd7;
    wait_rsp(ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_x !== 8'd8 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b x=%0d id=%0d err=%b req_ready=%b want 1 8 0 0 0000",
                 i, rsp_valid, rsp_x, rsp_id, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL bp_release_cycle: req_ready=%b want 0000", req_ready);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_next_grant: busy=%b req_ready=%b want 0 0100", busy, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_x !== 8'd10 || rsp_id !== 2'd2) begin
      n_bad++;
      $display("FAIL bp_next_rsp: x=%0d id=%0d want 10 2", rsp_x, rsp_id);
    end
    consume();
  endtask

  task automatic test_reset_mid_run;
    logic [NREQ-1:0] g;
    bit ok;
    bit seen;
    hang = 1'b1;
    issue(2, 8'd7);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0100) begin
      n_bad++;
      $display("FAIL rst_grant: got %b want 0100", g);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || inv_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pre_run: busy=%b inv_reset=%b want 1 0", busy, inv_reset);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hang  = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || inv_reset !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_abort: response or busy seen after reset, last valid=%b busy=%b", rsp_valid, busy);
    end
    req_valid = 4'b1001;
    req_a     = {8'd5, 8'd0, 8'd0, 8'd3};
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_next_grant: got %b want 0001", g);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || rsp_x !== 8'd8 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_next_rsp: x=%0d id=%0d err=%b want 8 0 0", rsp_x, rsp_id, rsp_err);
    end
    consume();
  endtask

  initial begin
    reset     = 1'b1;
    p         = 8'd23;
    req_valid = '0;
    req_a     = '0;
    rsp_ready = 1'b0;
    hang      = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
